axi4lite_apb_bridge: RTL
========================

Name: axi4lite_apb_bridge

Overview:
AXI4-Lite slave to APB4 master bridge. It sits directly upstream of the APB delayer and peripheral fabric, and converts each AXI4-Lite read or write into one APB SETUP/ACCESS transfer. Only one transfer is outstanding at a time. An optional ACCESS-phase timeout converts a hung slave into an SLVERR response.

Parameters:
ADDR_W, 32, address width (AXI and APB)
DATA_W, 32, data width; strobe width is DATA_W/8
TIMEOUT, 0, maximum ACCESS cycles without pready before forced SLVERR; 0 disables the timeout

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
in_awvalid/in_awready  in/out  1  AW handshake
in_awaddr  in  ADDR_W  write address
in_awprot  in  3  write protection
in_wvalid/in_wready  in/out  1  W handshake
in_wdata  in  DATA_W  write data
in_wstrb  in  DATA_W/8  write strobes
in_bvalid/in_bready  out/in  1  B handshake
in_bresp  out  2  write response
in_arvalid/in_arready  in/out  1  AR handshake
in_araddr  in  ADDR_W  read address
in_arprot  in  3  read protection
in_rvalid/in_rready  out/in  1  R handshake
in_rdata  out  DATA_W  read data
in_rresp  out  2  read response
out_paddr  out  ADDR_W  APB address
out_psel  out  1  APB select
out_penable  out  1  APB enable
out_pprot  out  3  APB protection
out_pwrite  out  1  APB direction
out_pwdata  out  DATA_W  APB write data
out_pstrb  out  DATA_W/8  APB strobes
out_pready  in  1  APB ready
out_prdata  in  DATA_W  APB read data
out_pslverr  in  1  APB slave error

Behaviour:
- Reset (reset=0): all outputs 0; state IDLE; priority flag = read-first; timeout counter 0. Takes effect asynchronously, so psel/penable drop immediately mid-transfer and any in-flight transaction is lost.
- All out_* signals and in_*valid/resp/data outputs are registered.
- In IDLE, in_awready, in_wready and in_arready are driven combinationally from the arbiter; they are 0 in every other state.
- Write candidate exists only when in_awvalid && in_wvalid. AW and W are accepted together in the same cycle; a lone AW or lone W is never accepted.
- Arbitration: if only one candidate exists, grant it. If both exist, grant per the priority flag, then toggle the flag. The flag changes only on contended grants.
- States:
  - IDLE: on grant, latch paddr/pprot/pwrite. For writes also latch pwdata=wdata, pstrb=wstrb. For reads pwdata=0, pstrb=0. Go to SETUP.
  - SETUP: psel=1, penable=0. Go to ACCESS next cycle.
  - ACCESS: psel=1, penable=1. On out_pready: capture prdata (reads) and pslverr, drop psel/penable, go to RESP.
  - ACCESS timeout: if TIMEOUT!=0 and the counter reaches TIMEOUT-1 without pready, terminate with SLVERR, rdata=0, and go to RESP.
  - RESP: bvalid (write) or rvalid (read) held with stable data until the matching ready; then go to IDLE. No new accept in the same cycle.
- resp encoding: OKAY=2'b00, SLVERR=2'b10. No other values are produced.
- Latency: accept at cycle T -> SETUP T+1 -> ACCESS T+2 -> valid at T+3 when pready=1 at T+2. Minimum 4 cycles per transfer, including the IDLE cycle.
- Timeout counter: cleared on SETUP entry, increments each ACCESS cycle. pready and timeout in the same cycle: pready wins.
- Address is forwarded unmodified (no alignment/decode). prot is passed through.
- APB signals are stable for the whole transfer, per APB4.

Decomposition:
- Package axi4lite_apb_pkg holds:
  - state enum {IDLE, SETUP, ACCESS, RESP}
  - RESP_OKAY and RESP_SLVERR constants
- Single module. The arbiter and timeout counter are small enough to stay inline; no sub-module.

Test Plan:
- Write 0x1000_0004 / 0xDEAD_BEEF, strb 4'b0011, pready=1 first ACCESS cycle -> SETUP at T+1, ACCESS at T+2 with paddr/pwdata/pstrb matching, bvalid at T+3 with bresp=00.
- Read 0x1000_0000, slave holds pready=0 for 5 cycles then returns 0x1234_5678 -> psel held 7 cycles, rvalid with rdata=0x1234_5678, rresp=00, pstrb=0 throughout.
- Simultaneous AR+AW+W from reset, repeated 4 times -> grant order R,W,R,W.
- AW only, with W arriving 3 cycles later -> awready stays 0 until wvalid=1, then both handshake together.
- TIMEOUT=8, slave never asserts pready -> ACCESS lasts exactly 8 cycles, rresp=10, rdata=0, bridge back in IDLE after rready.
- reset=0 during ACCESS -> psel/penable are 0 before the next clock edge; after release, a new read completes normally.

Source files
------------

// File: rtl/axi4lite_apb_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to APB4 bridge.
package axi4lite_apb_pkg;

    // Transfer sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // AXI response encodings produced by the bridge.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi4lite_apb_bridge_if.sv
// Bundles the AXI4-Lite slave side and APB4 master side of the bridge.
// The slave modport is the bridge view; the master modport is the view of
// whatever sits around it (AXI initiator plus APB completer).
interface axi4lite_apb_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  in_awvalid;
    logic                  in_awready;
    logic [ADDR_W-1:0]     in_awaddr;
    logic [2:0]            in_awprot;
    logic                  in_wvalid;
    logic                  in_wready;
    logic [DATA_W-1:0]     in_wdata;
    logic [DATA_W/8-1:0]   in_wstrb;
    logic                  in_bvalid;
    logic                  in_bready;
    logic [1:0]            in_bresp;
    logic                  in_arvalid;
    logic                  in_arready;
    logic [ADDR_W-1:0]     in_araddr;
    logic [2:0]            in_arprot;
    logic                  in_rvalid;
    logic                  in_rready;
    logic [DATA_W-1:0]     in_rdata;
    logic [1:0]            in_rresp;

    logic [ADDR_W-1:0]     out_paddr;
    logic                  out_psel;
    logic                  out_penable;
    logic [2:0]            out_pprot;
    logic                  out_pwrite;
    logic [DATA_W-1:0]     out_pwdata;
    logic [DATA_W/8-1:0]   out_pstrb;
    logic                  out_pready;
    logic [DATA_W-1:0]     out_prdata;
    logic                  out_pslverr;

    modport slave (
        input  in_awvalid, in_awaddr, in_awprot,
        input  in_wvalid, in_wdata, in_wstrb,
        input  in_bready,
        input  in_arvalid, in_araddr, in_arprot,
        input  in_rready,
        output in_awready, in_wready,
        output in_bvalid, in_bresp,
        output in_arready,
        output in_rvalid, in_rdata, in_rresp,
        output out_paddr, out_psel, out_penable, out_pprot,
        output out_pwrite, out_pwdata, out_pstrb,
        input  out_pready, out_prdata, out_pslverr
    );

    modport master (
        output in_awvalid, in_awaddr, in_awprot,
        output in_wvalid, in_wdata, in_wstrb,
        output in_bready,
        output in_arvalid, in_araddr, in_arprot,
        output in_rready,
        input  in_awready, in_wready,
        input  in_bvalid, in_bresp,
        input  in_arready,
        input  in_rvalid, in_rdata, in_rresp,
        input  out_paddr, out_psel, out_penable, out_pprot,
        input  out_pwrite, out_pwdata, out_pstrb,
        output out_pready, out_prdata, out_pslverr
    );

endinterface

// File: rtl/axi4lite_apb_bridge.sv
// AXI4-Lite slave to APB4 master bridge, one transfer in flight at a time.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | arbitrating; readies driven combinationally from the grant
//   SETUP  | psel=1, penable=0, APB request fields latched and stable
//   ACCESS | psel=1, penable=1, waiting for pready or the timeout
//   RESP   | bvalid/rvalid held until the matching ready handshake
import axi4lite_apb_pkg::*;

module axi4lite_apb_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 0
) (
    input logic                   clock,
    input logic                   reset,
    axi4lite_apb_bridge_if.slave  bus
);

    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int STRB_W = DATA_W / 8;

    state_t             state;
    state_t             state_nxt;
    logic               prio_rd;
    logic [CNT_W-1:0]   tmo_cnt;

    logic               rd_cand;
    logic               wr_cand;
    logic               contended;
    logic               grant_rd;
    logic               grant_wr;
    logic               timeout_hit;
    logic               access_done;
    logic               resp_done;
    logic [1:0]         resp_code;

    assign rd_cand   = bus.in_arvalid;
    assign wr_cand   = bus.in_awvalid && bus.in_wvalid;
    assign contended = rd_cand && wr_cand;

    // Arbiter: grants only in IDLE; a lone AW or W never forms a candidate.
    always_comb begin
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (state == IDLE) begin
            if (contended) begin
                grant_rd = prio_rd;
                grant_wr = !prio_rd;
            end else begin
                grant_rd = rd_cand;
                grant_wr = wr_cand;
            end
        end
    end

    assign bus.in_arready = grant_rd;
    assign bus.in_awready = grant_wr;
    assign bus.in_wready  = grant_wr;

    // pready takes precedence over an expiring timeout in the same cycle.
    assign timeout_hit = (TIMEOUT != 0) && !bus.out_pready
                         && (tmo_cnt == CNT_W'(TIMEOUT - 1));
    assign access_done = bus.out_pready || timeout_hit;
    assign resp_code   = (bus.out_pready && !bus.out_pslverr) ? RESP_OKAY : RESP_SLVERR;
    assign resp_done   = (bus.in_bvalid && bus.in_bready) || (bus.in_rvalid && bus.in_rready);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_rd || grant_wr) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (access_done) state_nxt = RESP;
            RESP:    if (resp_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Priority flag flips only when both candidates competed for the grant.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                           prio_rd <= 1'b1;
        else if (state == IDLE && contended)  prio_rd <= !prio_rd;
    end

    // ACCESS-phase watchdog: zeroed as a transfer is accepted, counts ACCESS cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                                   tmo_cnt <= '0;
        else if (grant_rd || grant_wr)                tmo_cnt <= '0;
        else if (state == ACCESS && !access_done)     tmo_cnt <= tmo_cnt + CNT_W'(1);
    end

    // APB request fields, latched at grant and held for the whole transfer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.out_paddr  <= '0;
            bus.out_pprot  <= '0;
            bus.out_pwrite <= 1'b0;
            bus.out_pwdata <= '0;
            bus.out_pstrb  <= '0;
        end else if (grant_rd) begin
            bus.out_paddr  <= bus.in_araddr;
            bus.out_pprot  <= bus.in_arprot;
            bus.out_pwrite <= 1'b0;
            bus.out_pwdata <= '0;
            bus.out_pstrb  <= '0;
        end else if (grant_wr) begin
            bus.out_paddr  <= bus.in_awaddr;
            bus.out_pprot  <= bus.in_awprot;
            bus.out_pwrite <= 1'b1;
            bus.out_pwdata <= bus.in_wdata;
            bus.out_pstrb  <= STRB_W'(bus.in_wstrb);
        end
    end

    // APB phase controls: psel rises into SETUP, penable into ACCESS, both drop at completion.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.out_psel    <= 1'b0;
            bus.out_penable <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_rd || grant_wr) bus.out_psel <= 1'b1;
                end
                SETUP: begin
                    bus.out_penable <= 1'b1;
                end
                ACCESS: begin
                    if (access_done) begin
                        bus.out_psel    <= 1'b0;
                        bus.out_penable <= 1'b0;
                    end
                end
                default: begin
                    bus.out_psel    <= 1'b0;
                    bus.out_penable <= 1'b0;
                end
            endcase
        end
    end

    // Response channels: loaded when ACCESS finishes, released on the AXI handshake.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.in_bvalid <= 1'b0;
            bus.in_bresp  <= RESP_OKAY;
            bus.in_rvalid <= 1'b0;
            bus.in_rresp  <= RESP_OKAY;
            bus.in_rdata  <= '0;
        end else begin
            if (state == ACCESS && access_done) begin
                if (bus.out_pwrite) begin
                    bus.in_bvalid <= 1'b1;
                    bus.in_bresp  <= resp_code;
                end else begin
                    bus.in_rvalid <= 1'b1;
                    bus.in_rresp  <= resp_code;
                    bus.in_rdata  <= bus.out_pready ? bus.out_prdata : '0;
                end
            end
            if (bus.in_bvalid && bus.in_bready) bus.in_bvalid <= 1'b0;
            if (bus.in_rvalid && bus.in_rready) bus.in_rvalid <= 1'b0;
        end
    end

endmodule
